// File: rtl/ram_responder_if.sv
// rtl/ram_responder_if.sv - cache-to-RAM word request/done handshake bundle
interface ram_responder_if;
    logic        RAMSchreiben;
    logic        RAMLesen;
    logic [31:0] RAMAdresse;
    logic [31:0] RAMSchreibDaten;
    logic [31:0] RAMLesDaten;
    logic        RAMDatenGeschrieben;
    logic        RAMDatenGelesen;

    // Cache side: raises request levels and waits for the done pulses.
    modport master (
        output RAMSchreiben,
        output RAMLesen,
        output RAMAdresse,
        output RAMSchreibDaten,
        input  RAMLesDaten,
        input  RAMDatenGeschrieben,
        input  RAMDatenGelesen
    );

    // RAM side: answers each request with one done pulse.
    modport slave (
        input  RAMSchreiben,
        input  RAMLesen,
        input  RAMAdresse,
        input  RAMSchreibDaten,
        output RAMLesDaten,
        output RAMDatenGeschrieben,
        output RAMDatenGelesen
    );
endinterface

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - word RAM responder with programmable wait states; optional RAM_RESPONDER_BOUNDS_EN
module ram_responder #(
    parameter int ADDRBITS   = 14,
    parameter int WAITCYCLES = 3
) (
    input  logic           Clock,
    input  logic           Reset,
    ram_responder_if.slave bus
`ifdef RAM_RESPONDER_BOUNDS_EN
    ,
    output logic           AdressFehler
`endif
);
    localparam int         DEPTH     = 2 ** ADDRBITS;
    localparam logic [7:0] WAIT_INIT = 8'(WAITCYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic        op_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;

    logic [31:0] mem [DEPTH];

    logic                req;
    logic                access_now;
    logic                acc_write;
    logic [31:0]         acc_addr;
    logic [31:0]         acc_data;
    logic [ADDRBITS-1:0] acc_index;
    logic                acc_oob;
    logic                mem_we;

    assign req = bus.RAMSchreiben | bus.RAMLesen;

    // Pick the operands of the access committed at this edge: with zero wait
    // states the access happens straight from IDLE using the live inputs,
    // otherwise from the values latched when the request was sampled.
    always_comb begin
        access_now = 1'b0;
        acc_write  = op_write;
        acc_addr   = lat_addr;
        acc_data   = lat_data;
        if (state == IDLE) begin
            acc_write  = bus.RAMSchreiben;
            acc_addr   = bus.RAMAdresse;
            acc_data   = bus.RAMSchreibDaten;
            access_now = req && (WAIT_INIT == 8'd0);
        end else if (state == WAIT) begin
            access_now = (wait_cnt == 8'd1);
        end
    end

    assign acc_index = acc_addr[ADDRBITS-1:0];

`ifdef RAM_RESPONDER_BOUNDS_EN
    assign acc_oob = (acc_addr >> ADDRBITS) != 32'd0;
`else
    // Upper address bits alias onto the array.
    assign acc_oob = 1'b0;
    logic unused_addr_hi;
    assign unused_addr_hi = |acc_addr[31:ADDRBITS];
`endif

    // A reset on the commit edge discards the write.
    assign mem_we = access_now && acc_write && !acc_oob && !Reset;

    // Memory array, deliberately left uninitialised by reset.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[acc_index] <= acc_data;
        end
    end

    // Request FSM: sample in IDLE, count wait states, pulse done for one cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state                   <= IDLE;
            wait_cnt                <= 8'd0;
            op_write                <= 1'b0;
            lat_addr                <= 32'd0;
            lat_data                <= 32'd0;
            bus.RAMLesDaten         <= 32'd0;
            bus.RAMDatenGeschrieben <= 1'b0;
            bus.RAMDatenGelesen     <= 1'b0;
        end else begin
            bus.RAMDatenGeschrieben <= 1'b0;
            bus.RAMDatenGelesen     <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_write <= bus.RAMSchreiben;
                        lat_addr <= bus.RAMAdresse;
                        lat_data <= bus.RAMSchreibDaten;
                        wait_cnt <= WAIT_INIT;
                        state    <= (WAIT_INIT == 8'd0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 8'd1;
                    if (wait_cnt == 8'd1) begin
                        state <= ACK;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
            if (access_now) begin
                if (acc_write) begin
                    bus.RAMDatenGeschrieben <= 1'b1;
                end else begin
                    bus.RAMDatenGelesen <= 1'b1;
                    bus.RAMLesDaten     <= acc_oob ? 32'hDEADBEEF : mem[acc_index];
                end
            end
        end
    end

`ifdef RAM_RESPONDER_BOUNDS_EN
    // Sticky out-of-range flag, visible from the ACK cycle onwards.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            AdressFehler <= 1'b0;
        end else if (access_now && acc_oob) begin
            AdressFehler <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard bench for ram_responder at 3 and 0 wait states
module tb_ram_responder;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    always #5 Clock = ~Clock;

    ram_responder_if bus3();
    ram_responder_if bus0();
`ifdef RAM_RESPONDER_BOUNDS_EN
    logic fehler3, fehler0;
`endif

    ram_responder #(.ADDRBITS(14), .WAITCYCLES(3)) dut3 (
        .Clock(Clock), .Reset(Reset), .bus(bus3)
`ifdef RAM_RESPONDER_BOUNDS_EN
        , .AdressFehler(fehler3)
`endif
    );
    ram_responder #(.ADDRBITS(14), .WAITCYCLES(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .bus(bus0)
`ifdef RAM_RESPONDER_BOUNDS_EN
        , .AdressFehler(fehler0)
`endif
    );

    typedef struct {
        bit          wr;
        logic [31:0] data;
    } exp_t;

    exp_t sb3[$];
    exp_t sb0[$];
    int checks   = 0;
    int failures = 0;
    logic [31:0] model [int];

    int          lat;
    logic [31:0] rd;

    function automatic int model_key(input logic [31:0] a);
        return int'({18'd0, a[13:0]});
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
`ifdef RAM_RESPONDER_BOUNDS_EN
        if (a[31:14] != 18'd0) return 32'hDEADBEEF;
`endif
        if (model.exists(model_key(a))) return model[model_key(a)];
        return 32'd0;
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [31:0] d);
`ifdef RAM_RESPONDER_BOUNDS_EN
        if (a[31:14] != 18'd0) return;
`endif
        model[model_key(a)] = d;
    endfunction

    // Scoreboard for the 3-wait-state responder.
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset && (bus3.RAMDatenGeschrieben || bus3.RAMDatenGelesen)) begin
            checks++;
            if (sb3.size() == 0) begin
                failures++;
                $display("FAIL sb3_stray_pulse wr=%0b rd=%0b", bus3.RAMDatenGeschrieben, bus3.RAMDatenGelesen);
            end else begin
                e = sb3.pop_front();
                if (bus3.RAMDatenGeschrieben !== e.wr || bus3.RAMDatenGelesen !== !e.wr) begin
                    failures++;
                    $display("FAIL sb3_op got wr=%0b rd=%0b want wr=%0b", bus3.RAMDatenGeschrieben, bus3.RAMDatenGelesen, e.wr);
                end else if (!e.wr && bus3.RAMLesDaten !== e.data) begin
                    failures++;
                    $display("FAIL sb3_data got %h want %h", bus3.RAMLesDaten, e.data);
                end
            end
        end
    end

    // Scoreboard for the zero-wait-state responder.
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset && (bus0.RAMDatenGeschrieben || bus0.RAMDatenGelesen)) begin
            checks++;
            if (sb0.size() == 0) begin
                failures++;
                $display("FAIL sb0_stray_pulse wr=%0b rd=%0b", bus0.RAMDatenGeschrieben, bus0.RAMDatenGelesen);
            end else begin
                e = sb0.pop_front();
                if (bus0.RAMDatenGeschrieben !== e.wr || bus0.RAMDatenGelesen !== !e.wr) begin
                    failures++;
                    $display("FAIL sb0_op got wr=%0b rd=%0b want wr=%0b", bus0.RAMDatenGeschrieben, bus0.RAMDatenGelesen, e.wr);
                end else if (!e.wr && bus0.RAMLesDaten !== e.data) begin
                    failures++;
                    $display("FAIL sb0_data got %h want %h", bus0.RAMLesDaten, e.data);
                end
            end
        end
    end

    // One transaction on the 3-wait-state responder; lat is the cycle of the
    // done pulse counted from the request's first cycle (cycle 0), -1 on timeout.
    task automatic single3(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        @(negedge Clock);
        bus3.RAMAdresse      = addr;
        bus3.RAMSchreibDaten = data;
        bus3.RAMSchreiben    = wr;
        bus3.RAMLesen        = !wr;
        e.wr   = wr;
        e.data = wr ? data : model_rd(addr);
        sb3.push_back(e);
        if (wr) model_wr(addr, data);
        lat = -1;
        rd  = 32'hx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge Clock);
            if (bus3.RAMDatenGeschrieben || bus3.RAMDatenGelesen) begin
                lat = n;
                rd  = bus3.RAMLesDaten;
                break;
            end
        end
        bus3.RAMSchreiben = 1'b0;
        bus3.RAMLesen     = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        checks++;
        if ({bus3.RAMDatenGeschrieben, bus3.RAMDatenGelesen, bus0.RAMDatenGeschrieben, bus0.RAMDatenGelesen} !== 4'b0
            || bus3.RAMLesDaten !== 32'd0 || bus0.RAMLesDaten !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs got %h/%h pulses %b%b%b%b want 0", bus3.RAMLesDaten, bus0.RAMLesDaten,
                     bus3.RAMDatenGeschrieben, bus3.RAMDatenGelesen, bus0.RAMDatenGeschrieben, bus0.RAMDatenGelesen);
        end
`ifdef RAM_RESPONDER_BOUNDS_EN
        checks++;
        if (fehler3 !== 1'b0) begin
            failures++;
            $display("FAIL reset_fehler got %b want 0", fehler3);
        end
`endif
        Reset = 1'b0;
    endtask

    task automatic test_write_read();
        single3(1'b1, 32'h10, 32'h12345678);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL wr_latency got %0d want 4", lat);
        end
        @(negedge Clock);
        checks++;
        if (bus3.RAMDatenGeschrieben !== 1'b0) begin
            failures++;
            $display("FAIL wr_pulse_width got %b want 0", bus3.RAMDatenGeschrieben);
        end
        single3(1'b0, 32'h10, 32'h0);
        checks++;
        if (lat !== 4 || rd !== 32'h12345678) begin
            failures++;
            $display("FAIL rd_single got lat=%0d data=%h want lat=4 data=12345678", lat, rd);
        end
    endtask

    task automatic test_burst();
        exp_t e;
        int pulse_at[4];
        int cnt;
        for (int i = 0; i < 4; i++) single3(1'b1, 32'h40 + i, 32'hB0C0_0000 + 32'(i * 4099));
        for (int i = 0; i < 4; i++) begin
            e.wr   = 1'b0;
            e.data = model_rd(32'h40 + i);
            sb3.push_back(e);
        end
        @(negedge Clock);
        bus3.RAMAdresse = 32'h40;
        bus3.RAMLesen   = 1'b1;
        cnt = 0;
        for (int n = 1; n <= 60 && cnt < 4; n++) begin
            @(negedge Clock);
            if (bus3.RAMDatenGelesen) begin
                pulse_at[cnt] = n;
                cnt++;
                bus3.RAMAdresse = 32'h40 + cnt;
                if (cnt == 4) bus3.RAMLesen = 1'b0;
            end
        end
        bus3.RAMLesen = 1'b0;
        checks++;
        if (cnt !== 4 || pulse_at[0] !== 4) begin
            failures++;
            $display("FAIL burst3_count got cnt=%0d first=%0d want 4/4", cnt, pulse_at[0]);
        end
        for (int i = 1; i < cnt; i++) begin
            checks++;
            if (pulse_at[i] - pulse_at[i-1] !== 5) begin
                failures++;
                $display("FAIL burst3_spacing idx=%0d got %0d want 5", i, pulse_at[i] - pulse_at[i-1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] words[4];
        int pulse_at[4];
        int cnt;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                if (pass == 0) words[i] = $urandom;
                e.wr   = (pass == 0);
                e.data = words[i];
                sb0.push_back(e);
            end
            @(negedge Clock);
            bus0.RAMAdresse      = 32'h80;
            bus0.RAMSchreibDaten = words[0];
            bus0.RAMSchreiben    = (pass == 0);
            bus0.RAMLesen        = (pass == 1);
            cnt = 0;
            for (int n = 1; n <= 40 && cnt < 4; n++) begin
                @(negedge Clock);
                if (bus0.RAMDatenGeschrieben || bus0.RAMDatenGelesen) begin
                    pulse_at[cnt] = n;
                    cnt++;
                    bus0.RAMAdresse = 32'h80 + cnt;
                    if (cnt < 4) bus0.RAMSchreibDaten = words[cnt];
                    else begin
                        bus0.RAMSchreiben = 1'b0;
                        bus0.RAMLesen     = 1'b0;
                    end
                end
            end
            bus0.RAMSchreiben = 1'b0;
            bus0.RAMLesen     = 1'b0;
            checks++;
            if (cnt !== 4 || pulse_at[0] !== 1) begin
                failures++;
                $display("FAIL b2b_count pass=%0d got cnt=%0d first=%0d want 4/1", pass, cnt, pulse_at[0]);
            end
            for (int i = 1; i < cnt; i++) begin
                checks++;
                if (pulse_at[i] - pulse_at[i-1] !== 2) begin
                    failures++;
                    $display("FAIL b2b_spacing pass=%0d idx=%0d got %0d want 2", pass, i, pulse_at[i] - pulse_at[i-1]);
                end
            end
        end
    endtask

    task automatic test_both_high();
        exp_t e;
        logic saw_read;
        single3(1'b0, 32'h10, 32'h0);
        @(negedge Clock);
        bus3.RAMAdresse      = 32'h20;
        bus3.RAMSchreibDaten = 32'hA5A5A5A5;
        bus3.RAMSchreiben    = 1'b1;
        bus3.RAMLesen        = 1'b1;
        e.wr   = 1'b1;
        e.data = 32'hA5A5A5A5;
        sb3.push_back(e);
        model_wr(32'h20, 32'hA5A5A5A5);
        lat = -1;
        saw_read = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge Clock);
            if (bus3.RAMDatenGelesen) saw_read = 1'b1;
            if (bus3.RAMDatenGeschrieben) begin
                lat = n;
                break;
            end
        end
        bus3.RAMSchreiben = 1'b0;
        bus3.RAMLesen     = 1'b0;
        checks++;
        if (lat !== 4 || saw_read !== 1'b0 || bus3.RAMLesDaten !== 32'h12345678) begin
            failures++;
            $display("FAIL both_high got lat=%0d read=%b data=%h want 4/0/12345678", lat, saw_read, bus3.RAMLesDaten);
        end
        single3(1'b0, 32'h20, 32'h0);
        checks++;
        if (rd !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL both_high_mem got %h want a5a5a5a5", rd);
        end
    endtask

    task automatic test_reset_mid_write();
        int stray;
        single3(1'b1, 32'h30, 32'h11111111);
        @(negedge Clock);
        bus3.RAMAdresse      = 32'h30;
        bus3.RAMSchreibDaten = 32'h22222222;
        bus3.RAMSchreiben    = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        bus3.RAMSchreiben = 1'b0;
        @(negedge Clock);
        checks++;
        if (bus3.RAMDatenGeschrieben !== 1'b0 || bus3.RAMDatenGelesen !== 1'b0 || bus3.RAMLesDaten !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset_outputs got %b%b %h want 00 0", bus3.RAMDatenGeschrieben, bus3.RAMDatenGelesen, bus3.RAMLesDaten);
        end
        Reset = 1'b0;
        stray = 0;
        repeat (8) begin
            @(negedge Clock);
            if (bus3.RAMDatenGeschrieben || bus3.RAMDatenGelesen) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL mid_reset_pulse got %0d want 0", stray);
        end
        single3(1'b0, 32'h30, 32'h0);
        checks++;
        if (lat !== 4 || rd !== 32'h11111111) begin
            failures++;
            $display("FAIL mid_reset_mem got lat=%0d data=%h want 4/11111111", lat, rd);
        end
    endtask

`ifdef RAM_RESPONDER_BOUNDS_EN
    task automatic test_bounds();
        single3(1'b0, 32'h4000, 32'h0);
        checks++;
        if (lat !== 4 || rd !== 32'hDEADBEEF || fehler3 !== 1'b1) begin
            failures++;
            $display("FAIL bounds_read got lat=%0d data=%h flag=%b want 4/deadbeef/1", lat, rd, fehler3);
        end
        single3(1'b1, 32'h4010, 32'hCAFEF00D);
        single3(1'b0, 32'h10, 32'h0);
        repeat (4) @(negedge Clock);
        checks++;
        if (rd !== 32'h12345678 || fehler3 !== 1'b1) begin
            failures++;
            $display("FAIL bounds_hold got data=%h flag=%b want 12345678/1", rd, fehler3);
        end
    endtask
`else
    task automatic test_alias();
        single3(1'b1, 32'h4010, 32'hCAFEF00D);
        single3(1'b0, 32'h10, 32'h0);
        checks++;
        if (lat !== 4 || rd !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL alias_read got lat=%0d data=%h want 4/cafef00d", lat, rd);
        end
    endtask
`endif

    initial begin
        bus3.RAMSchreiben = 1'b0; bus3.RAMLesen = 1'b0; bus3.RAMAdresse = 32'd0; bus3.RAMSchreibDaten = 32'd0;
        bus0.RAMSchreiben = 1'b0; bus0.RAMLesen = 1'b0; bus0.RAMAdresse = 32'd0; bus0.RAMSchreibDaten = 32'd0;
        test_reset();
        test_write_read();
        test_burst();
        test_back_to_back();
        test_both_high();
        test_reset_mid_write();
`ifdef RAM_RESPONDER_BOUNDS_EN
        test_bounds();
`else
        test_alias();
`endif
        repeat (4) @(negedge Clock);
        checks++;
        if (sb3.size() != 0 || sb0.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d/%0d pending want 0/0", sb3.size(), sb0.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
